idct8x8_2d: RTL and testbench

Inverse 2-D 8x8 DCT: takes one 8x8 block of coefficients as 8 row beats and returns the spatial block as 8 column beats. It is the decode-side counterpart of the forward DCT datapath. The block is row–column separable: a row IDCT pass writes an internal transpose buffer, then a column IDCT pass reads it and drives the output handshake. One shared 8-point 1-D IDCT unit serves both passes.

---
 rtl/idct_pkg.sv | 22 ++
 rtl/idct8_1d.sv | 28 ++
 rtl/idct8x8_2d.sv | 142 ++++++++++++++
 tb/tb_idct8x8_2d.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants, basis matrix and FSM state type for the 8x8 inverse DCT.
// The output saturation option of the top level is selected by IDCT_OUT_SAT_EN.
package idct_pkg;

  localparam int COEF_FRAC = 12;
  localparam int ROUND     = 2048;

  // T[k][n] = round(4096 * alpha(k) * cos((2n+1)k*pi/16))
  localparam int T [8][8] = '{
    '{ 1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
    '{ 2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
    '{ 1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
    '{ 1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
    '{ 1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
    '{ 1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
    '{  784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
    '{  400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
  };

  typedef enum logic {S_ROWS, S_COLS} state_e;

endpackage

// File: rtl/idct8_1d.sv
// Combinational 8-point 1-D IDCT: full-precision dot products, +ROUND, arithmetic
// shift by COEF_FRAC (floor), result truncated to W_OUT bits.
module idct8_1d
  import idct_pkg::*;
#(
  parameter int W_IN  = 19,
  parameter int W_OUT = 20
) (
  input  logic signed [W_IN-1:0]  d_i [8],
  output logic signed [W_OUT-1:0] q_o [8]
);

  // Coefficients stay below 2^11 and eight terms are summed.
  localparam int ACC_W = W_IN + 16;

  logic signed [ACC_W-1:0] acc [8];

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      acc[n] = ACC_W'(ROUND);
      for (int k = 0; k < 8; k++) begin
        acc[n] = acc[n] + ACC_W'(T[k][n]) * ACC_W'(d_i[k]);
      end
      q_o[n] = W_OUT'(acc[n] >>> COEF_FRAC);
    end
  end

endmodule

// File: rtl/idct8x8_2d.sv
// Row/column separable 8x8 inverse DCT sharing one 1-D unit between both passes.
// Define IDCT_OUT_SAT_EN to saturate the column result; otherwise it wraps.
module idct8x8_2d
  import idct_pkg::*;
#(
  parameter int WIDTH_X = 16,
  parameter int WIDTH_Y = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_X-1:0] x0, x1, x2, x3, x4, x5, x6, x7,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic signed [WIDTH_Y-1:0] y0, y1, y2, y3, y4, y5, y6, y7
);

  localparam int WIDTH_M = WIDTH_X + 3;
  localparam int WIDTH_U = WIDTH_X + 4;

  state_e                    state_q, state_d;
  logic [2:0]                row_cnt_q, row_cnt_d;
  logic [3:0]                col_cnt_q, col_cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic signed [WIDTH_Y-1:0] y_q [8];
  logic signed [WIDTH_Y-1:0] y_d [8];
  logic signed [WIDTH_M-1:0] mem_q [8][8];

  logic signed [WIDTH_X-1:0] x_vec    [8];
  logic signed [WIDTH_M-1:0] unit_in  [8];
  logic signed [WIDTH_U-1:0] unit_out [8];
  logic signed [WIDTH_Y-1:0] y_red    [8];
  logic                      row_acc, col_load, blk_done;

  assign x_vec    = '{x0, x1, x2, x3, x4, x5, x6, x7};
  assign in_ready = (state_q == S_ROWS) && !rst;
  assign row_acc  = in_valid && in_ready;
  assign col_load = (state_q == S_COLS) && (col_cnt_q < 4'd8) && (!out_valid_q || out_ready);
  assign blk_done = (state_q == S_COLS) && (col_cnt_q == 4'd8) && out_valid_q && out_ready;

  // Rows come straight from the ports; columns come from the transpose buffer.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      unit_in[k] = (state_q == S_ROWS) ? WIDTH_M'(x_vec[k]) : mem_q[k][col_cnt_q[2:0]];
    end
  end

  idct8_1d #(
    .W_IN  (WIDTH_M),
    .W_OUT (WIDTH_U)
  ) u_idct (
    .d_i (unit_in),
    .q_o (unit_out)
  );

  always_comb begin
    for (int n = 0; n < 8; n++) begin
`ifdef IDCT_OUT_SAT_EN
      if (unit_out[n] > WIDTH_U'((2 ** (WIDTH_Y - 1)) - 1)) begin
        y_red[n] = {1'b0, {(WIDTH_Y - 1){1'b1}}};
      end else if (unit_out[n] < -WIDTH_U'(2 ** (WIDTH_Y - 1))) begin
        y_red[n] = {1'b1, {(WIDTH_Y - 1){1'b0}}};
      end else begin
        y_red[n] = WIDTH_Y'(unit_out[n]);
      end
`else
      y_red[n] = WIDTH_Y'(unit_out[n]);
`endif
    end
  end

  // NOTE: every next-state signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    y_d         = y_q;
    if (row_acc) begin
      row_cnt_d = row_cnt_q + 3'd1;
      if (row_cnt_q == 3'd7) begin
        state_d   = S_COLS;
        row_cnt_d = 3'd0;
      end
    end
    if (col_load) begin
      y_d         = y_red;
      out_valid_d = 1'b1;
      out_last_d  = (col_cnt_q == 4'd7);
      col_cnt_d   = col_cnt_q + 4'd1;
    end else if (blk_done) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      col_cnt_d   = 4'd0;
      state_d     = S_ROWS;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ROWS;
      row_cnt_q   <= 3'd0;
      col_cnt_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      y_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      y_q         <= y_d;
    end
  end

  // NOTE: the transpose buffer is deliberately not reset; every block rewrites all rows.
  always_ff @(posedge clk) begin
    if (row_acc) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[row_cnt_q][c] <= WIDTH_M'(unit_out[c]);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];
  assign y4 = y_q[4];
  assign y5 = y_q[5];
  assign y6 = y_q[6];
  assign y7 = y_q[7];

endmodule

// File: tb/tb_idct8x8_2d.sv
// Scoreboard bench for idct8x8_2d: a real-valued reference builds the expected columns,
// a monitor compares every presented beat. Honors IDCT_OUT_SAT_EN for the reduction rule.
module tb_idct8x8_2d;

  localparam int WX  = 16;
  localparam int WY  = 16;
  localparam int WY9 = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [WX-1:0]  xs  [8];
  logic                  in_ready, out_valid, out_last;
  logic signed [WY-1:0]  ys  [8];
  logic                  in_ready9, out_valid9, out_last9;
  logic signed [WY9-1:0] ys9 [8];

  always #5 clk = ~clk;

  idct8x8_2d #(.WIDTH_X(WX), .WIDTH_Y(WY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]), .x3(xs[3]),
    .x4(xs[4]), .x5(xs[5]), .x6(xs[6]), .x7(xs[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .y0(ys[0]), .y1(ys[1]), .y2(ys[2]), .y3(ys[3]),
    .y4(ys[4]), .y5(ys[5]), .y6(ys[6]), .y7(ys[7])
  );

  idct8x8_2d #(.WIDTH_X(WX), .WIDTH_Y(WY9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]), .x3(xs[3]),
    .x4(xs[4]), .x5(xs[5]), .x6(xs[6]), .x7(xs[7]),
    .out_valid(out_valid9), .out_ready(out_ready), .out_last(out_last9),
    .y0(ys9[0]), .y1(ys9[1]), .y2(ys9[2]), .y3(ys9[3]),
    .y4(ys9[4]), .y5(ys9[5]), .y6(ys9[6]), .y7(ys9[7])
  );

  typedef struct packed {
    logic [7:0][WY-1:0]  y16;
    logic [7:0][WY9-1:0] y9;
    logic                last;
  } beat_t;

  beat_t exp_q [$];
  beat_t mon_e;
  int    total = 0;
  int    bad   = 0;
  int    tc  [8][8];
  int    blk [8][8];
  int    rdy_mode = 0;
  int    rdy_cnt  = 0;
  bit    stall_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int tcoef(int k, int n);
    real a, v;
    a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
    v = 4096.0 * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979323846 / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic longint wrapw(longint v, int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic longint reduce(longint v, int w);
`ifdef IDCT_OUT_SAT_EN
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    return wrapw(v, w);
`endif
  endfunction

  // Reference: floor-rounded row pass into a WX+3 buffer, column pass, then reduce.
  task automatic push_block();
    longint z [8][8];
    longint s, v;
    beat_t  b;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) begin
        s = 2048;
        for (int k = 0; k < 8; k++) s += longint'(tc[k][n]) * longint'(blk[r][k]);
        z[r][n] = wrapw(s >>> 12, WX + 3);
      end
    for (int c = 0; c < 8; c++) begin
      b = '0;
      for (int n = 0; n < 8; n++) begin
        s = 2048;
        for (int k = 0; k < 8; k++) s += longint'(tc[k][n]) * z[k][c];
        v = wrapw(s >>> 12, WX + 4);
        b.y16[n] = WY'(reduce(v, WY));
        b.y9[n]  = WY9'(reduce(v, WY9));
      end
      b.last = (c == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic set_dc(input int dc);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) blk[r][k] = 0;
    blk[0][0] = dc;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send_block();
    push_block();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) xs[k] = WX'(blk[r][k]);
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("first_valid_early", out_valid, 0);
    @(negedge clk);
    check("first_valid", out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      1:       out_ready = (rdy_cnt % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
    rdy_cnt++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) check("hold_valid", out_valid, 1);
      if (out_valid || out_valid9) check("valid_match", out_valid9, out_valid);
      if (out_valid) begin
        check("in_ready_busy", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          mon_e = exp_q[0];
          for (int n = 0; n < 8; n++) begin
            check($sformatf("y16[%0d]", n), longint'(ys[n]), longint'($signed(mon_e.y16[n])));
            check($sformatf("y9[%0d]", n), longint'(ys9[n]), longint'($signed(mon_e.y9[n])));
          end
          check("last", out_last, mon_e.last);
          check("last9", out_last9, mon_e.last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) tc[k][n] = tcoef(k, n);
    for (int k = 0; k < 8; k++) xs[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    for (int n = 0; n < 8; n++) check($sformatf("rst_y[%0d]", n), longint'(ys[n]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    set_dc(64);    send_block();
    set_dc(800);   send_block();
    set_dc(-800);  send_block();
    drain();

    rdy_mode = 1;
    set_dc(800);   send_block();
    drain();
    rdy_mode = 0;

    set_dc(32767); send_block();
    drain();

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) xs[k] = WX'($urandom_range(0, 4095)) - WX'(2048);
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("postrst_valid", out_valid, 0);
    check("postrst_ready", in_ready, 1);
    @(posedge clk); #1;
    set_dc(64);    send_block();

    for (int b = 0; b < 12; b++) begin
      rdy_mode = b % 3;
      for (int r = 0; r < 8; r++)
        for (int k = 0; k < 8; k++)
          blk[r][k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2047)) - 1024;
      send_block();
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
